// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter: op encodings and controller states.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    CLR = 2'b01,
    SET = 2'b10,
    ILL = 2'b11
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester was not granted last.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of SR flags written by two round-robin arbitrated requesters; each op is
// latched in IDLE and applied as a single set or clear strobe in APPLY.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int IDXW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [IDXW-1:0]   req0_idx,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [IDXW-1:0]   req1_idx,
  output logic [NFLAGS-1:0] q,
  output logic [NFLAGS-1:0] q_bar,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  op_e               op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NFLAGS-1:0] q_q, q_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic              grant_en;
  logic              accept;
  logic              idx_ok;
  logic [NFLAGS-1:0] idx_onehot;
  logic [NFLAGS-1:0] set_vec;
  logic [NFLAGS-1:0] clr_vec;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Readies only in IDLE and never while reset is held, so nothing is accepted under reset.
  assign grant_en   = (state_q == IDLE) && rst_n;
  assign req0_ready = grant_en && grant[0];
  assign req1_ready = grant_en && grant[1];
  assign accept     = req0_ready || req1_ready;

  assign idx_ok     = ({1'b0, idx_q} < (IDXW + 1)'(NFLAGS));
  assign idx_onehot = NFLAGS'(1) << idx_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    idx_d        = idx_q;
    q_d          = q_q;
    err_d        = err_q;
    set_vec      = '0;
    clr_vec      = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = APPLY;
          if (grant[0]) begin
            op_d         = op_e'(req0_op);
            idx_d        = req0_idx;
            last_grant_d = 1'b0;
          end else begin
            op_d         = op_e'(req1_op);
            idx_d        = req1_idx;
            last_grant_d = 1'b1;
          end
        end
      end

      APPLY: begin
        state_d = IDLE;
        op_d    = NOP;
        // Only one op is in flight, so set and clear can never target a bit together.
        if (op_q == ILL || !idx_ok) begin
          err_d = 1'b1;
        end else if (op_q == SET) begin
          set_vec = idx_onehot;
        end else if (op_q == CLR) begin
          clr_vec = idx_onehot;
        end
        q_d = (q_q | set_vec) & ~clr_vec;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= NOP;
      idx_q        <= '0;
      q_q          <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      q_q          <= q_d;
      err_q        <= err_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;
  assign busy  = (state_q == APPLY);
  assign err   = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: one task per scenario with hand-computed
// expectations for readies, busy, err and the flag vector.
module tb_sr_flag_arbiter;

  localparam int NFLAGS = 4;
  localparam int IDXW   = 2;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [1:0]        req0_op, req1_op;
  logic [IDXW-1:0]   req0_idx, req1_idx;
  logic [NFLAGS-1:0] q, q_bar;
  logic              busy, err;

  int vectors     = 0;
  int miscompares = 0;

  sr_flag_arbiter #(.NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_idx   (req0_idx),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_idx   (req1_idx),
    .q          (q),
    .q_bar      (q_bar),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = OP_NOP; req0_idx = '0;
    req1_valid = 1'b0; req1_op = OP_NOP; req1_idx = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one op from a lone requester and let it complete (accept edge + apply edge).
  task automatic setup_op(input bit which, input logic [1:0] op, input logic [IDXW-1:0] idx);
    if (!which) begin
      req0_valid = 1'b1; req0_op = op; req0_idx = idx;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_idx = idx;
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = OP_SET; req0_idx = 2'd3;
    req1_valid = 1'b1; req1_op = OP_SET; req1_idx = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_ready cycle %0d: got %b expected 00", i, {req1_ready, req0_ready});
      end
      tick();
    end
    vectors++;
    if ({q, q_bar, err, busy} !== {4'b0000, 4'b1111, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got q=%b q_bar=%b err=%b busy=%b expected q=0000 q_bar=1111 err=0 busy=0",
               q, q_bar, err, busy);
    end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_set();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_SET; req0_idx = 2'd2;
    #1;
    vectors++;
    if ({req1_ready, req0_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL single_accept: got r1=%b r0=%b busy=%b expected r1=0 r0=1 busy=0", req1_ready, req0_ready, busy);
    end
    tick();
    clear_inputs();
    req0_valid = 1'b1; req0_op = OP_CLR; req0_idx = 2'd2;
    #1;
    vectors++;
    if ({req0_ready, busy, q} !== {1'b0, 1'b1, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL single_apply: got r0=%b busy=%b q=%b expected r0=0 busy=1 q=0000", req0_ready, busy, q);
    end
    clear_inputs();
    tick();
    vectors++;
    if ({busy, q, q_bar} !== {1'b0, 4'b0100, 4'b1011}) begin
      miscompares++;
      $display("[TB] FAIL single_result: got busy=%b q=%b q_bar=%b expected busy=0 q=0100 q_bar=1011", busy, q, q_bar);
    end
  endtask

  task automatic test_nop();
    req0_valid = 1'b1; req0_op = OP_NOP; req0_idx = 2'd2;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nop_accept: got r0=%b expected 1", req0_ready);
    end
    tick();
    clear_inputs();
    tick();
    vectors++;
    if ({q, err} !== {4'b0100, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL nop_result: got q=%b err=%b expected q=0100 err=0", q, err);
    end
  endtask

  task automatic test_contention();
    do_reset();
    setup_op(1'b1, OP_SET, 2'd1);
    vectors++;
    if (q !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL contend_setup: got q=%b expected 0010", q);
    end
    req0_valid = 1'b1; req0_op = OP_SET; req0_idx = 2'd1;
    req1_valid = 1'b1; req1_op = OP_CLR; req1_idx = 2'd1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL contend_first: got r1r0=%b expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    #1;
    vectors++;
    if ({req1_ready, req0_ready, busy} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL contend_apply0: got r1r0=%b busy=%b expected r1r0=00 busy=1", {req1_ready, req0_ready}, busy);
    end
    tick();
    vectors++;
    if ({req1_ready, req0_ready, q} !== {2'b10, 4'b0010}) begin
      miscompares++;
      $display("[TB] FAIL contend_second: got r1r0=%b q=%b expected r1r0=10 q=0010", {req1_ready, req0_ready}, q);
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if ({req1_ready, req0_ready, busy} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL contend_apply1: got r1r0=%b busy=%b expected r1r0=00 busy=1", {req1_ready, req0_ready}, busy);
    end
    tick();
    vectors++;
    if (q !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL contend_result: got q=%b expected 0000", q);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_r [8];
    int accepts;
    exp_r = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    accepts = 0;
    do_reset();
    req0_valid = 1'b1; req0_op = OP_NOP; req0_idx = 2'd0;
    req1_valid = 1'b1; req1_op = OP_NOP; req1_idx = 2'd0;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== exp_r[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_grant cycle %0d: got r1r0=%b expected %b", i, {req1_ready, req0_ready}, exp_r[i]);
      end
      if (req0_ready || req1_ready) accepts++;
      tick();
    end
    clear_inputs();
    vectors++;
    if (accepts !== 4) begin
      miscompares++;
      $display("[TB] FAIL rr_accepts: got %0d expected 4", accepts);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    setup_op(1'b0, OP_SET, 2'd0);
    req1_valid = 1'b1; req1_op = OP_ILL; req1_idx = 2'd0;
    #1;
    vectors++;
    if ({req1_ready, q, err} !== {1'b1, 4'b0001, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ill_accept: got r1=%b q=%b err=%b expected r1=1 q=0001 err=0", req1_ready, q, err);
    end
    tick();
    clear_inputs();
    vectors++;
    if ({busy, err} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL ill_apply: got busy=%b err=%b expected busy=1 err=0", busy, err);
    end
    tick();
    vectors++;
    if ({q, err} !== {4'b0001, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ill_result: got q=%b err=%b expected q=0001 err=1", q, err);
    end
    setup_op(1'b0, OP_SET, 2'd3);
    vectors++;
    if ({q, err} !== {4'b1001, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ill_sticky_set: got q=%b err=%b expected q=1001 err=1", q, err);
    end
    setup_op(1'b1, OP_CLR, 2'd0);
    vectors++;
    if ({q, err} !== {4'b1000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL ill_sticky_clr: got q=%b err=%b expected q=1000 err=1", q, err);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_SET; req0_idx = 2'd3;
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, req0_ready, req1_ready} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL midrst_apply: got busy=%b r0=%b r1=%b expected busy=1 r0=0 r1=0", busy, req0_ready, req1_ready);
    end
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({q, busy, err} !== {4'b0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_after: got q=%b busy=%b err=%b expected q=0000 busy=0 err=0", q, busy, err);
    end
    tick();
    tick();
    tick();
    vectors++;
    if ({q, busy} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_replay: got q=%b busy=%b expected q=0000 busy=0", q, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_SET; req0_idx = 2'd0;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got r0=%b expected 1", req0_ready);
    end
    tick();
    req0_op = OP_SET; req0_idx = 2'd1;
    #1;
    vectors++;
    if ({req0_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_hold: got r0=%b busy=%b expected r0=0 busy=1", req0_ready, busy);
    end
    tick();
    vectors++;
    if ({req0_ready, q} !== {1'b1, 4'b0001}) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got r0=%b q=%b expected r0=1 q=0001", req0_ready, q);
    end
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (q !== 4'b0011) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: got q=%b expected 0011", q);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_set();
    test_nop();
    test_contention();
    test_round_robin();
    test_illegal();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

Interface
REQ-001 SHALL have parameter NFLAGS, default 4, meaning the number of SR flag bits held (2..16).
REQ-002 SHALL have parameter IDXW, default 2, meaning the flag index width; it SHALL equal clog2(NFLAGS).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the reset; it is synchronous and active-low.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each, meaning requester 0/1 presents an op.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each, meaning requester 0/1 op accepted this cycle.
REQ-007 SHALL have ports req0_op and req1_op, input, 2 bits each: 00 nop, 01 clear, 10 set, 11 illegal.
REQ-008 SHALL have ports req0_idx and req1_idx, input, IDXW bits each, meaning the target flag.
REQ-009 SHALL have port q, output, NFLAGS bits, meaning the flag state.
REQ-010 SHALL have port q_bar, output, NFLAGS bits, meaning the bitwise inverse of q at all times.
REQ-011 SHALL have port busy, output, 1 bit, high while state is APPLY.
REQ-012 SHALL have port err, output, 1 bit, a sticky illegal-op flag.

Function
REQ-013 SHALL implement FSM states IDLE and APPLY; IDLE->APPLY on any accept; APPLY->IDLE unconditionally after one cycle.
REQ-014 SHALL assert readyN combinationally in IDLE only, for at most one requester per cycle, and only when that requester's valid is high.
REQ-015 SHALL accept at most one op per cycle; an accept is validN && readyN at a rising edge.
REQ-016 SHALL arbitrate with round-robin: when both are valid in IDLE, grant the requester not granted last; last_grant resets to 1, so requester 0 wins first.
REQ-017 SHALL grant a single valid requester immediately, regardless of last_grant, and update last_grant to it.
REQ-018 SHALL latch the accepted op and idx in IDLE, then drive exactly one set or clear strobe in APPLY; q[idx] updates on the edge leaving APPLY (latency 2 edges from accept).
REQ-019 SHALL leave the other q bits unchanged on every op; nop SHALL change no flag.
REQ-020 SHALL never drive set and clear to the same bit in one cycle; the forbidden SR state is unreachable.
REQ-021 SHALL treat op 11 as illegal: accept it, change no flag, and set err on the APPLY edge.
REQ-022 SHALL hold err high until reset.
REQ-023 SHALL ignore idx values >= NFLAGS: accept the op, change no flag, and set err.
REQ-024 SHALL hold a losing requester off with ready low; it is served in the next IDLE cycle if still valid.
REQ-025 SHALL NOT require requesters to hold inputs stable after accept.
REQ-026 SHALL accept a new op in the cycle following APPLY, giving a maximum throughput of one op per 2 cycles.

Reset
REQ-027 SHALL, with rst_n low at an edge, force: state IDLE, q all 0, q_bar all 1, err 0, busy 0, last_grant 1, latched op nop.
REQ-028 SHALL discard an op that is in APPLY when reset is asserted; the flag SHALL NOT update.
REQ-029 SHALL hold req0_ready and req1_ready low while rst_n is low.

Structure
REQ-030 SHALL place the op encodings (NOP, CLR, SET, ILL) and the FSM state enum in shared package sr_flag_pkg.
REQ-031 SHALL isolate the round-robin grant logic in one sub-module, rr_arb2 (inputs: two valids, last_grant; outputs: one-hot grant).

Verification
REQ-032 SHALL cover reset: hold rst_n low for 3 cycles with both valids high -> q=0000, q_bar=1111, err=0, both readys stay 0.
REQ-033 SHALL cover a single set: req0 set idx2 -> req0_ready 1 for one cycle, busy 1 for the next cycle, then q=0100.
REQ-034 SHALL cover contention: both valid, req0 set idx1, req1 clear idx1 from q=0010 -> req0 first (q=0010), then req1 (q=0000), with no cycle having both readys high.
REQ-035 SHALL cover round-robin fairness: both held valid for 8 cycles -> grants alternate 0,1,0,1, with 4 accepts total.
REQ-036 SHALL cover an illegal op: req1 op 11 idx0 with q=0001 -> q stays 0001, err rises and stays 1 through later legal ops.
REQ-037 SHALL cover reset mid-operation: rst_n low during APPLY of set idx3 -> q=0000 after reset, and the op is not replayed.
